retire_ctrl: RTL
================

# retire_ctrl

Retire sequencer between the ROB head and the architectural register file. Each cycle it retires up to two completed ROB head entries in order. Their results go into a small write buffer that drains to the single regfile write port at one entry per cycle. The block also sequences branch-mispredict squash and program halt. A bypass port lets dispatch see buffered values that have not yet reached the regfile.

## Interface
Parameters:
- XLEN, 32, data width
- WB_DEPTH, 4, write-buffer entries (power of 2, at least 2)

Ports:
- clock  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- h0_valid, h1_valid  in  1 each  ROB head / head+1 entry exists
- h0_complete, h1_complete  in  1 each  entry has finished executing
- h0_r, h1_r  in  5 each  destination architectural register (0 = no write)
- h0_V, h1_V  in  XLEN each  result value
- h0_mispred, h1_mispred  in  1 each  entry is a mispredicted branch
- h0_target, h1_target  in  XLEN each  correct PC for a mispredicted branch
- h0_halt, h1_halt  in  1 each  entry is a halt instruction
- rob_retire_cnt  out  2  ROB entries popped this cycle (0..2), combinational
- wb_regfile_en  out  1  regfile write enable
- wb_regfile_idx  out  5  regfile write index
- wb_regfile_data  out  XLEN  regfile write data
- squash  out  1  one-cycle flush pulse to ROB, RS and fetch
- redirect_pc  out  XLEN  fetch redirect target; valid while squash=1
- q_idx  in  5  bypass lookup register
- q_hit  out  1  q_idx has a pending write in the buffer
- q_data  out  XLEN  value of the youngest matching buffer entry
- halted  out  1  sticky halt indication

## Operation
- The FSM has four states: RUN, SQUASH, HALT_DRAIN and HALTED. Reset puts it in RUN.
- Free-slot count: free = WB_DEPTH − count + (count≠0). This credits the entry that drains in the same cycle.
- An entry needs a slot only if r≠0. An entry with r=0 retires without pushing.
- Lane 0 retires when all of these hold:
  - state is RUN;
  - h0_valid and h0_complete;
  - a slot is available if one is needed.
- Lane 1 retires when all of these hold:
  - lane 0 retires;
  - h0_mispred=0 and h0_halt=0;
  - h1_valid and h1_complete;
  - enough slots remain for both entries.
- rob_retire_cnt is the number of lanes retiring this cycle.
- Buffer push order is lane 0 then lane 1, so buffer order matches program order.
- Drain: whenever count≠0, the head entry is presented on wb_regfile_* with en=1 and is popped at the clock edge. The regfile always accepts.
- Mispredict: the retiring lane with mispred=1 (and halt=0) is the last retire. The FSM goes to SQUASH and redirect_pc is latched from that lane's target.
- SQUASH state:
  - squash=1 for exactly one cycle; no retire in this cycle;
  - buffered writes keep draining, because they are older than the branch;
  - next state is RUN.
- Halt: a retiring lane with halt=1 moves the FSM to HALT_DRAIN. Halt has priority over mispred on the same entry.
- HALT_DRAIN: no retire; the FSM moves to HALTED on the cycle count reaches 0.
- HALTED: halted=1, no retire, wb_regfile_en=0. The FSM leaves HALTED only on reset.
- Bypass:
  - q_hit=1 iff q_idx≠0 and some valid buffer entry has r=q_idx;
  - q_data is the youngest such entry;
  - the entry being drained this cycle still counts;
  - entries pushed this cycle do not count;
  - q_hit and q_data are combinational.

## Timing
- Reset values: state RUN, buffer empty (head, tail and count = 0), squash=0, redirect_pc=0, halted=0, wb_regfile_en=0, wb_regfile_idx=0, wb_regfile_data=0, rob_retire_cnt=0, q_hit=0.
- Latency: an entry retired at cycle t is written to the regfile no earlier than t+1, and exactly at t+1+(entries ahead of it).
- squash is asserted in the cycle after the mispredicting branch retires. RUN resumes the cycle after squash.
- Buffer full (count=WB_DEPTH) with no drain is impossible, because the buffer drains every cycle it holds an entry. Retire stalls only while free < needed.
- Head and tail pointers wrap modulo WB_DEPTH. count is $clog2(WB_DEPTH)+1 bits wide.
- Asserting reset_n=0 mid-squash or mid-drain clears everything immediately and discards pending writes.

## Test plan
- Push 2 completed entries per cycle (r=1..8, V=0x10..0x80) → cnt=2 while space allows, then drops to 1. Regfile writes appear in order, one per cycle, starting the cycle after the first retire.
- Lane 0 has r=0 and lane 1 has r=5 with the buffer holding 3 of 4 entries → cnt=2, one push, 5 written last.
- Lane 0 mispred with target 0x400 and lane 1 complete → cnt=1; next cycle squash=1 and redirect_pc=0x400; cnt=0 during squash; RUN the cycle after.
- Lane 1 halt with 2 writes buffered → cnt=2; writes drain over 3 cycles; halted=1 the cycle after count reaches 0; cnt stays 0 afterwards.
- Buffer holds r=7 twice (V=0xA, then 0xB); q_idx=7 → q_hit=1, q_data=0xB; q_idx=0 → q_hit=0.
- Drop reset_n while in SQUASH with 3 entries buffered → all outputs are 0 in the same cycle and no regfile writes occur after reset is released.

Source files
------------

// File: rtl/retire_ctrl.sv
// Retire sequencer: retires up to two completed ROB head entries per cycle into a
// small write buffer that drains one entry per cycle to the regfile; handles squash and halt.
module retire_ctrl #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned WB_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            h0_valid,
  input  logic            h1_valid,
  input  logic            h0_complete,
  input  logic            h1_complete,
  input  logic [4:0]      h0_r,
  input  logic [4:0]      h1_r,
  input  logic [XLEN-1:0] h0_V,
  input  logic [XLEN-1:0] h1_V,
  input  logic            h0_mispred,
  input  logic            h1_mispred,
  input  logic [XLEN-1:0] h0_target,
  input  logic [XLEN-1:0] h1_target,
  input  logic            h0_halt,
  input  logic            h1_halt,
  output logic [1:0]      rob_retire_cnt,
  output logic            wb_regfile_en,
  output logic [4:0]      wb_regfile_idx,
  output logic [XLEN-1:0] wb_regfile_data,
  output logic            squash,
  output logic [XLEN-1:0] redirect_pc,
  input  logic [4:0]      q_idx,
  output logic            q_hit,
  output logic [XLEN-1:0] q_data,
  output logic            halted
);

  localparam int unsigned PW = $clog2(WB_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {RUN, SQUASH, HALT_DRAIN, HALTED} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] redirect_nxt;

  logic [4:0]      buf_r [WB_DEPTH];
  logic [XLEN-1:0] buf_v [WB_DEPTH];
  logic [PW-1:0]   head, tail, tail1;
  logic [CW-1:0]   count, free, need0, need1;
  logic            lane0, lane1, push0, push1, pop;

  // Slot accounting credits the entry draining this cycle.
  assign free  = CW'(WB_DEPTH) - count + CW'(count != '0);
  assign need0 = CW'(h0_r != 5'd0);
  assign need1 = CW'(h1_r != 5'd0);

  assign lane0 = (state == RUN) && reset_n && h0_valid && h0_complete && (free >= need0);
  assign lane1 = lane0 && !h0_mispred && !h0_halt && h1_valid && h1_complete &&
                 (free >= need0 + need1);

  assign push0 = lane0 && (h0_r != 5'd0);
  assign push1 = lane1 && (h1_r != 5'd0);
  assign pop   = (count != '0);
  assign tail1 = push0 ? tail + PW'(1) : tail;

  assign rob_retire_cnt  = 2'(lane0) + 2'(lane1);
  assign wb_regfile_en   = pop;
  assign wb_regfile_idx  = pop ? buf_r[head] : 5'd0;
  assign wb_regfile_data = pop ? buf_v[head] : '0;
  assign squash          = (state == SQUASH);
  assign halted          = (state == HALTED);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      redirect_pc <= '0;
    end else begin
      state       <= state_nxt;
      redirect_pc <= redirect_nxt;
    end
  end

  // Next state; the last retiring lane decides squash/halt, halt winning over mispred
  always_comb begin
    state_nxt    = state;
    redirect_nxt = redirect_pc;
    case (state)
      RUN: begin
        if (lane1) begin
          if (h1_halt) begin
            state_nxt = HALT_DRAIN;
          end else if (h1_mispred) begin
            state_nxt    = SQUASH;
            redirect_nxt = h1_target;
          end
        end else if (lane0) begin
          if (h0_halt) begin
            state_nxt = HALT_DRAIN;
          end else if (h0_mispred) begin
            state_nxt    = SQUASH;
            redirect_nxt = h0_target;
          end
        end
      end
      SQUASH:     state_nxt = RUN;
      HALT_DRAIN: if (count == '0) state_nxt = HALTED;
      HALTED:     state_nxt = HALTED;
      default:    state_nxt = RUN;
    endcase
  end

  // Write buffer: lane 0 pushes ahead of lane 1 to keep program order
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < int'(WB_DEPTH); i++) begin
        buf_r[i] <= 5'd0;
        buf_v[i] <= '0;
      end
    end else begin
      if (pop) head <= head + PW'(1);
      if (push0) begin
        buf_r[tail] <= h0_r;
        buf_v[tail] <= h0_V;
      end
      if (push1) begin
        buf_r[tail1] <= h1_r;
        buf_v[tail1] <= h1_V;
      end
      tail  <= tail + PW'(push0) + PW'(push1);
      count <= count - CW'(pop) + CW'(push0) + CW'(push1);
    end
  end

  // Bypass: scan oldest to youngest so the youngest match wins
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    for (int i = 0; i < int'(WB_DEPTH); i++) begin
      if ((CW'(i) < count) && (q_idx != 5'd0) && (buf_r[head + PW'(i)] == q_idx)) begin
        q_hit  = 1'b1;
        q_data = buf_v[head + PW'(i)];
      end
    end
  end

endmodule
